dec_poly_tomsg: RTL and testbench
=================================

# dec_poly_tomsg

Reads the 32 words of the decryption difference polynomial (v − INTT(sᵀu)) written by the poly-subtract stage into the Sub BRAM. Compresses each of the 256 coefficients to one bit (Kyber Compress_q(x,1)). Streams the resulting 32-byte message to the downstream re-encryption/hash stage over a valid/ready byte interface. It is the reader side of the Sub output buffer.

## Interface
- KYBER_N, 256, coefficients per polynomial
- KYBER_Q, 3329, modulus
- LANE_W, 16, bit width of one coefficient lane in a Sub BRAM word
- WORD_W, 128, Sub BRAM data width (8 lanes)
- SUB_BASE, 64, Sub BRAM address of the first DecMp word
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  start pulse; sampled only in IDLE
- Sub_RData  input  128  Sub BRAM read data; synchronous read, 1-cycle latency
- Sub_RAd  output  8  Sub BRAM read address
- msg_byte  output  8  message byte; bit j = compressed coefficient 8k+j
- msg_idx  output  5  index k (0-31) of msg_byte
- msg_valid  output  1  msg_byte/msg_idx valid
- msg_ready  input  1  downstream accepts byte when high with msg_valid
- Function_done  output  1  one-cycle pulse after byte 31 is accepted
- busy  output  1  high from enable acceptance until Function_done

## Operation
- Lane j of a word is Sub_RData[16j+15:16j]; lane 0 is the lowest coefficient.
- Per lane, the value is taken as unsigned 16-bit c. Compute c' = c − Q if c ≥ Q, else c. A single conditional subtract is used; input is guaranteed < 2Q.
- The bit is 1 iff 833 ≤ c' ≤ 2496. This equals ((2c'+1664)/3329) & 1.
- FSM states: IDLE, ADDR, CAPT, EMIT, DONE.
  - IDLE: on enable, Sub_RAd ← SUB_BASE, msg_idx ← 0, busy ← 1, go to ADDR.
  - ADDR: go to CAPT (the BRAM samples the address).
  - CAPT: msg_byte ← compress(Sub_RData), msg_valid ← 1, go to EMIT.
  - EMIT: hold while !msg_ready. On msg_valid & msg_ready, msg_valid ← 0.
    - If msg_idx = 31: Function_done ← 1, busy ← 0, go to DONE.
    - Otherwise: msg_idx+1, Sub_RAd+1, go to ADDR.
  - DONE: Function_done ← 0, go to IDLE.
- enable outside IDLE is ignored, with no restart and no queuing.
- msg_byte and msg_idx stay stable while msg_valid = 1 and msg_ready = 0.
- Sub_RAd never leaves SUB_BASE..SUB_BASE+31 during a run. It holds its last value after the run.

## Timing
- Reset values: Sub_RAd 0, msg_byte 0, msg_idx 0, msg_valid 0, Function_done 0, busy 0, state IDLE.
- Asserting rst_n low mid-run aborts immediately: all outputs go to reset values and no partial Function_done is issued.
- With enable accepted at edge 0 and msg_ready held high:
  - byte k is valid after edge 2+3k and accepted at edge 3+3k;
  - byte 31 is accepted at edge 96;
  - Function_done is high for the single cycle after edge 96;
  - the block is back in IDLE after edge 97.
- Minimum 3 cycles per byte. Each cycle of msg_ready = 0 in EMIT adds exactly one cycle.
- A new enable in the IDLE cycle right after DONE starts a new run.
- Compression is combinational from Sub_RData into the msg_byte register, with no extra pipeline stage.

## Structure
- Shared package (kyber_pkg): KYBER_Q, KYBER_N, the compress thresholds 833 and 2496, the lane width, and the FSM state encoding typedef.
- Sub-module dec_poly_tomsg_bit: combinational, 16-bit lane in, 1 bit out (conditional subtract plus range compare). Instantiated 8 times via generate.
- The top module holds the FSM, address/index counters and output registers, roughly 150-250 lines.

## Test plan
- All 32 words zero, msg_ready = 1 -> 32 bytes of 0x00, msg_idx 0..31 in order, Function_done 1 cycle after edge 96, Sub_RAd stepping 64..95.
- All lanes 1665 -> all bytes 0xFF. All lanes 3328 -> all bytes 0x00.
- Word with lanes 0..7 = 832, 833, 2496, 2497, 0, 1664, 3328, 3329 -> byte 0x26.
- Lanes 4994 (= Q+1665) and 3329 (= Q) -> bits 1 and 0 respectively (reduction check).
- msg_ready toggled randomly, including low for 5 cycles on byte 7 -> msg_byte/msg_idx stable while stalled, no byte lost or duplicated, total time 96 + stall cycles.
- Reset asserted at edge 40, then enable pulsed during the run -> all outputs at reset values, no Function_done. Enable pulsed while busy -> ignored; a fresh enable afterwards produces a full 32-byte run.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, 1-bit compression thresholds and the
// DecMp-to-message FSM encoding.
package kyber_pkg;

    localparam int          KYBER_N  = 256;
    localparam logic [15:0] KYBER_Q  = 16'd3329;
    localparam int          LANE_W   = 16;
    localparam int          WORD_W   = 128;
    localparam int          LANES    = WORD_W / LANE_W;
    localparam logic [7:0]  SUB_BASE = 8'd64;
    localparam logic [15:0] COMP_LO  = 16'd833;
    localparam logic [15:0] COMP_HI  = 16'd2496;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_CAPT = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } tomsg_state_e;

endpackage

// File: rtl/dec_poly_tomsg_bit.sv
// Compress_q(x,1) for one 16-bit lane: a single conditional subtract of Q
// (inputs are below 2Q), then the bit is set when the result is near Q/2.
import kyber_pkg::*;

module dec_poly_tomsg_bit (
    input  logic [LANE_W-1:0] lane,
    output logic              bit_out
);

    logic [LANE_W-1:0] lane_red_s;

    // reduce into [0, Q) and test the Q/4..3Q/4 window
    always_comb begin
        lane_red_s = lane;
        if (lane >= KYBER_Q) begin
            lane_red_s = lane - KYBER_Q;
        end else begin
            lane_red_s = lane;
        end
        bit_out = (lane_red_s >= COMP_LO) && (lane_red_s <= COMP_HI);
    end

endmodule

// File: rtl/dec_poly_tomsg.sv
// Reads 32 DecMp words from the Sub BRAM, compresses each to one message
// byte and streams the bytes out over a valid/ready interface.
import kyber_pkg::*;

module dec_poly_tomsg (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [WORD_W-1:0] Sub_RData,
    output logic [7:0]        Sub_RAd,
    output logic [7:0]        msg_byte,
    output logic [4:0]        msg_idx,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic              Function_done,
    output logic              busy
);

    tomsg_state_e state_r, state_nxt_s;

    logic [7:0] sub_rad_r,   sub_rad_nxt_s;
    logic [7:0] msg_byte_r,  msg_byte_nxt_s;
    logic [4:0] msg_idx_r,   msg_idx_nxt_s;
    logic       msg_valid_r, msg_valid_nxt_s;
    logic       done_r,      done_nxt_s;
    logic       busy_r,      busy_nxt_s;
    logic [7:0] comp_byte_s;
    logic       accept_s;
    logic       last_s;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            dec_poly_tomsg_bit u_bit (
                .lane    (Sub_RData[g*LANE_W +: LANE_W]),
                .bit_out (comp_byte_s[g])
            );
        end
    endgenerate

    assign accept_s = (state_r == ST_EMIT) && msg_valid_r && msg_ready;
    assign last_s   = (msg_idx_r == 5'd31);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: state_nxt_s = ST_CAPT;
            ST_CAPT: state_nxt_s = ST_EMIT;
            ST_EMIT: begin
                if (accept_s && last_s) begin
                    state_nxt_s = ST_DONE;
                end else if (accept_s) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        sub_rad_nxt_s   = sub_rad_r;
        msg_byte_nxt_s  = msg_byte_r;
        msg_idx_nxt_s   = msg_idx_r;
        msg_valid_nxt_s = msg_valid_r;
        done_nxt_s      = done_r;
        busy_nxt_s      = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    sub_rad_nxt_s = SUB_BASE;
                    msg_idx_nxt_s = 5'd0;
                    busy_nxt_s    = 1'b1;
                end else begin
                    busy_nxt_s    = 1'b0;
                end
            end
            ST_ADDR: begin
                msg_valid_nxt_s = 1'b0;
            end
            ST_CAPT: begin
                msg_byte_nxt_s  = comp_byte_s;
                msg_valid_nxt_s = 1'b1;
            end
            ST_EMIT: begin
                // address stays inside the 32-word window: it only advances before byte 31
                if (accept_s && last_s) begin
                    msg_valid_nxt_s = 1'b0;
                    done_nxt_s      = 1'b1;
                    busy_nxt_s      = 1'b0;
                end else if (accept_s) begin
                    msg_valid_nxt_s = 1'b0;
                    msg_idx_nxt_s   = msg_idx_r + 5'd1;
                    sub_rad_nxt_s   = sub_rad_r + 8'd1;
                end else begin
                    msg_valid_nxt_s = msg_valid_r;
                end
            end
            ST_DONE: begin
                done_nxt_s = 1'b0;
            end
            default: begin
                msg_valid_nxt_s = 1'b0;
                done_nxt_s      = 1'b0;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_rad_r   <= 8'd0;
            msg_byte_r  <= 8'd0;
            msg_idx_r   <= 5'd0;
            msg_valid_r <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            sub_rad_r   <= sub_rad_nxt_s;
            msg_byte_r  <= msg_byte_nxt_s;
            msg_idx_r   <= msg_idx_nxt_s;
            msg_valid_r <= msg_valid_nxt_s;
            done_r      <= done_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign Sub_RAd       = sub_rad_r;
    assign msg_byte      = msg_byte_r;
    assign msg_idx       = msg_idx_r;
    assign msg_valid     = msg_valid_r;
    assign Function_done = done_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_dec_poly_tomsg.sv
// Scoreboard bench for dec_poly_tomsg: a BRAM model feeds DecMp words,
// a reference compressor predicts each message byte.
module tb_dec_poly_tomsg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [127:0] Sub_RData;
    logic [7:0]   Sub_RAd;
    logic [7:0]   msg_byte;
    logic [4:0]   msg_idx;
    logic         msg_valid;
    logic         msg_ready;
    logic         Function_done;
    logic         busy;

    dec_poly_tomsg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .Sub_RData     (Sub_RData),
        .Sub_RAd       (Sub_RAd),
        .msg_byte      (msg_byte),
        .msg_idx       (msg_idx),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .Function_done (Function_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [127:0] mem [32];
    logic [12:0]  exp_q [$];
    int           ready_mode = 0;

    int         stall_cnt = 0;
    int         acc_cnt   = 0;
    int         done_cnt  = 0;
    int         done_edge = 0;
    bit         prev_hold = 1'b0;
    logic [7:0] held_byte = 8'd0;
    logic [4:0] held_idx  = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_bit(input int c);
        int r;
        r = (c >= 3329) ? c - 3329 : c;
        return ((2 * r + 1664) / 3329) % 2;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [127:0] w);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) begin
            b[j] = ref_bit(int'(w[16*j +: 16])) != 0;
        end
        return b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Sub BRAM model: synchronous read, one cycle latency
    always @(posedge clk) Sub_RData <= mem[Sub_RAd[4:0]];

    // ready driver, with a forced 5-cycle stall on byte 7 in random mode
    initial begin
        int stall7;
        stall7    = 0;
        msg_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!busy) stall7 = 0;
            if (ready_mode == 0) begin
                msg_ready = 1'b1;
            end else if (msg_valid && msg_idx == 5'd7 && stall7 < 5) begin
                msg_ready = 1'b0;
                stall7++;
            end else begin
                msg_ready = ($urandom_range(0, 9) >= 3);
            end
        end
    end

    // monitor: pops expected bytes on each handshake, checks stability under stall
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("stall_valid", {31'd0, msg_valid}, 32'd1);
                chk("stall_byte", {24'd0, msg_byte}, {24'd0, held_byte});
                chk("stall_idx", {27'd0, msg_idx}, {27'd0, held_idx});
            end
            if (busy) begin
                checks++;
                if (Sub_RAd < 8'd64 || Sub_RAd > 8'd95) begin
                    failures++;
                    $display("FAIL rad_range: got %0d expected 64..95", Sub_RAd);
                end
            end
            if (msg_valid) begin
                chk("rad_vs_idx", {24'd0, Sub_RAd}, 32'd64 + {27'd0, msg_idx});
            end
            if (msg_valid && msg_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte: got idx %0d byte 0x%0h expected none", msg_idx, msg_byte);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    chk("byte_idx", {19'd0, msg_idx, msg_byte}, {19'd0, e});
                end
                acc_cnt++;
            end
            prev_hold = msg_valid && !msg_ready;
            if (prev_hold) begin
                stall_cnt++;
                held_byte = msg_byte;
                held_idx  = msg_idx;
            end
            if (Function_done) begin
                done_cnt++;
                done_edge = cyc;
            end
        end
    end

    task automatic fill(input int mode);
        int v;
        for (int w = 0; w < 32; w++) begin
            for (int j = 0; j < 8; j++) begin
                case (mode)
                    0:       v = 0;
                    1:       v = 1665;
                    2:       v = 3328;
                    default: v = int'($urandom_range(0, 6657));
                endcase
                mem[w][16*j +: 16] = v[15:0];
            end
        end
        if (mode == 3) begin
            int pat [8];
            pat = '{832, 833, 2496, 2497, 0, 1664, 3328, 3329};
            for (int j = 0; j < 8; j++) begin
                v = pat[j];
                mem[0][16*j +: 16] = v[15:0];
                v = (j % 2 == 0) ? 4994 : 3329;
                mem[1][16*j +: 16] = v[15:0];
            end
        end
        for (int w = 0; w < 32; w++) begin
            logic [4:0] wi;
            wi = w[4:0];
            exp_q.push_back({wi, ref_byte(mem[w])});
        end
    endtask

    task automatic start(output int st_edge);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable  = 1'b0;
        st_edge = cyc;
    endtask

    task automatic do_run(input int mode, input int rmode, input bit poke);
        int s0, a0, d0, st_edge, t;
        fill(mode);
        ready_mode = rmode;
        s0 = stall_cnt;
        a0 = acc_cnt;
        d0 = done_cnt;
        start(st_edge);
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
            if (poke && (t == 20 || t == 60)) enable = 1'b1;
            else enable = 1'b0;
        end
        enable = 1'b0;
        if (done_cnt == d0) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: got no Function_done expected done within 3000 cycles");
        end
        chk("done_time", done_edge - st_edge, 96 + (stall_cnt - s0));
        @(negedge clk);
        @(negedge clk);
        chk("done_pulses", done_cnt - d0, 32'd1);
        chk("bytes_accepted", acc_cnt - a0, 32'd32);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, msg_valid}, 32'd0);
        chk("rad_hold", {24'd0, Sub_RAd}, 32'd95);
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rad"}, {24'd0, Sub_RAd}, 32'd0);
        chk({tag, "_byte"}, {24'd0, msg_byte}, 32'd0);
        chk({tag, "_idx"}, {27'd0, msg_idx}, 32'd0);
        chk({tag, "_valid"}, {31'd0, msg_valid}, 32'd0);
        chk({tag, "_done"}, {31'd0, Function_done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int st_edge, d0;
        rst_n  = 1'b0;
        enable = 1'b0;
        for (int w = 0; w < 32; w++) mem[w] = 128'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(0, 0, 1'b0);
        do_run(1, 0, 1'b0);
        do_run(2, 0, 1'b0);
        do_run(3, 1, 1'b1);
        do_run(4, 1, 1'b0);

        // abort mid-run with reset at edge 40, enable pulsed while held
        fill(4);
        ready_mode = 0;
        d0 = done_cnt;
        start(st_edge);
        while (cyc < st_edge + 39) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("abort");
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk_reset_vals("abort_en");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        do_run(4, 0, 1'b0);
        do_run(3, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
